// File: rtl/cs4_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cs4_pkg
// Purpose  : Shared opcodes, FSM encoding and opcode-field constants for the
//            computador_simple4 accumulator CPU.
// Revision : 1.0  initial release
// ============================================================================
package cs4_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HALT = 3'd0;
    localparam logic [OP_W-1:0] OP_LDA  = 3'd1;
    localparam logic [OP_W-1:0] OP_STA  = 3'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd5;
    localparam logic [OP_W-1:0] OP_JZ   = 3'd6;
    localparam logic [OP_W-1:0] OP_JN   = 3'd7;

    localparam logic [15:0] ICOUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cs4_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cs4_mem
// Purpose  : Unified program/data RAM, combinational read, synchronous write.
// Revision : 1.0  initial release
// ============================================================================
module cs4_mem
    import cs4_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    // Contents survive reset; the host is expected to preload them.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/computador_simple4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : computador_simple4
// Purpose  : Multicycle (FETCH/EXEC) accumulator CPU with host load port.
// Revision : 1.0  initial release
// ============================================================================
module computador_simple4
    import cs4_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          carry,
    output logic [15:0]   icount
);

    state_t          r_state;
    logic [DW-1:0]   r_acc;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_ia;
    logic [OP_W-1:0] r_op;
    logic            r_carry;
    logic [15:0]     r_icount;

    logic [AW-1:0]   w_raddr;
    logic [DW-1:0]   w_rdata;
    logic            w_ready;
    logic            w_host_we;
    logic            w_sta_we;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [DW-1:0]   w_wdata;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic            w_zero;
    logic            w_neg;

    // The single read port serves the fetch in FETCH and the operand in EXEC.
    assign w_raddr   = (r_state == ST_EXEC) ? r_ia : r_pc;
    assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_HALTED);
    assign w_host_we = w_ready && load_en;
    assign w_sta_we  = (r_state == ST_EXEC) && (r_op == OP_STA);
    assign w_we      = (w_host_we || w_sta_we) && reset;
    assign w_waddr   = w_sta_we ? r_ia  : load_addr;
    assign w_wdata   = w_sta_we ? r_acc : load_data;

    assign w_sum  = {1'b0, r_acc} + {1'b0, w_rdata};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_rdata};
    assign w_zero = (r_acc == '0);
    assign w_neg  = r_acc[DW-1];

    cs4_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_pc     <= '0;
            r_ia     <= '0;
            r_op     <= OP_HALT;
            r_carry  <= 1'b0;
            r_icount <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state  <= ST_FETCH;
                        r_acc    <= '0;
                        r_pc     <= '0;
                        r_carry  <= 1'b0;
                        r_icount <= '0;
                    end
                end
                ST_FETCH: begin
                    r_op    <= w_rdata[DW-1 -: OP_W];
                    r_ia    <= w_rdata[AW-1:0];
                    r_pc    <= r_pc + 1'b1;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_icount != ICOUNT_MAX) begin
                        r_icount <= r_icount + 16'd1;
                    end
                    r_state <= (r_op == OP_HALT) ? ST_HALTED : ST_FETCH;
                    case (r_op)
                        OP_LDA: r_acc <= w_rdata;
                        OP_ADD: {r_carry, r_acc} <= w_sum;
                        OP_SUB: {r_carry, r_acc} <= w_diff;
                        OP_JMP: r_pc <= r_ia;
                        OP_JZ:  if (w_zero) r_pc <= r_ia;
                        OP_JN:  if (w_neg)  r_pc <= r_ia;
                        default: ;
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acc    = r_acc;
    assign pc     = r_pc;
    assign busy   = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign halted = (r_state == ST_HALTED);
    assign carry  = r_carry;
    assign icount = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_computador_simple4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_computador_simple4
// Purpose  : Self-checking bench: directed tables, corner sequences and
//            random programs compared against an instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_computador_simple4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [15:0] acc;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        carry;
    logic [15:0] icount;

    int checks = 0;
    int errors = 0;

    computador_simple4 #(.DW(16), .AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .acc       (acc),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .carry     (carry),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] HALT = 3'd0, LDA = 3'd1, STA = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, JMP = 3'd5, JZ = 3'd6, JN = 3'd7;

    logic [15:0] tb_mem  [256];
    logic [15:0] mdl_mem [256];
    logic [15:0] mdl_acc;
    logic [7:0]  mdl_pc;
    logic        mdl_c;
    int          mdl_n;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] exp_acc;
        logic        exp_c;
    } vec_t;
    vec_t vt [6];

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [7:0] a);
        return {op, 5'b0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // cyc counts clock edges after the start edge until halted is seen.
    task automatic wait_halt(input int c0, output int cyc);
        cyc = c0;
        while (!halted && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (!halted) chk("halt_timeout", 64'(cyc), 64'(0));
    endtask

    // Instruction-level reference: executes the shadow memory image directly.
    task automatic run_model();
        int p, a_v, m, op, a;
        bit done;
        mdl_mem = tb_mem;
        p = 0; a_v = 0; mdl_c = 1'b0; mdl_n = 0; done = 1'b0;
        while (!done && mdl_n < 1000) begin
            op = int'(mdl_mem[p][15:13]);
            a  = int'(mdl_mem[p][7:0]);
            p  = (p + 1) % 256;
            mdl_n++;
            m = int'(mdl_mem[a]);
            case (op)
                0: done = 1'b1;
                1: a_v = m;
                2: mdl_mem[a] = a_v[15:0];
                3: begin mdl_c = (a_v + m) > 65535; a_v = (a_v + m) % 65536; end
                4: begin mdl_c = a_v < m; a_v = (a_v - m + 65536) % 65536; end
                5: p = a;
                6: if (a_v == 0) p = a;
                7: if (a_v >= 32768) p = a;
                default: ;
            endcase
        end
        mdl_acc = a_v[15:0];
        mdl_pc  = p[7:0];
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        vt[0] = '{16'h7FFF, 16'h0002, ADD, 16'h8001, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, ADD, 16'h0000, 1'b1};
        vt[2] = '{16'h0000, 16'h0001, SUB, 16'hFFFF, 1'b1};
        vt[3] = '{16'h0005, 16'h0003, SUB, 16'h0002, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, ADD, 16'h0000, 1'b1};
        vt[5] = '{16'h1234, 16'h1234, SUB, 16'h0000, 1'b0};

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("reset_outputs", {acc, pc, busy, halted, carry, icount}, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {acc, pc, busy, halted, carry, icount}, 64'd0);
        end

        // Add/store
        load(0, ins(LDA, 10)); load(1, ins(ADD, 11)); load(2, ins(STA, 12));
        load(3, ins(HALT, 0)); load(10, 16'h7FFF); load(11, 16'h0002); load(12, 16'h0000);
        pulse_start();
        wait_halt(0, cyc);
        chk("add_halt_cycles", 64'(cyc), 64'd8);
        chk("add_acc", acc, 16'h8001);
        chk("add_mem12", dut.u_mem.r_mem[12], 16'h8001);
        chk("add_carry", carry, 1'b0);
        chk("add_icount", icount, 16'd4);
        chk("add_pc", pc, 8'd4);
        chk("add_busy", busy, 1'b0);

        // ALU table
        for (int i = 0; i < 6; i++) begin
            load(0, ins(LDA, 100)); load(1, ins(vt[i].op, 101)); load(2, ins(HALT, 0));
            load(100, vt[i].a); load(101, vt[i].b);
            pulse_start();
            wait_halt(0, cyc);
            chk("tbl_cycles", 64'(cyc), 64'd6);
            chk("tbl_acc", acc, vt[i].exp_acc);
            chk("tbl_carry", carry, vt[i].exp_c);
            chk("tbl_icount", icount, 16'd3);
        end

        // Carry, borrow, wrap and JN
        load(0, ins(LDA, 10)); load(1, ins(ADD, 11)); load(2, ins(SUB, 11));
        load(3, ins(JN, 20)); load(4, ins(HALT, 0)); load(20, ins(HALT, 0));
        load(10, 16'hFFFF); load(11, 16'h0001);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("wrap_add_acc", acc, 16'h0000);
        chk("wrap_add_carry", carry, 1'b1);
        repeat (2) @(negedge clk);
        chk("wrap_sub_acc", acc, 16'hFFFF);
        chk("wrap_sub_carry", carry, 1'b1);
        wait_halt(6, cyc);
        chk("jn_cycles", 64'(cyc), 64'd10);
        chk("jn_pc", pc, 8'd21);
        chk("jn_icount", icount, 16'd5);

        // Countdown loop with JZ exit: LDA,(SUB,JZ,JMP)x2,SUB,JZ,HALT = 10
        load(0, ins(LDA, 30)); load(1, ins(SUB, 31)); load(2, ins(JZ, 4));
        load(3, ins(JMP, 1)); load(4, ins(HALT, 0)); load(30, 16'd3); load(31, 16'd1);
        run_model();
        pulse_start();
        wait_halt(0, cyc);
        chk("loop_icount", icount, 16'd10);
        chk("loop_model_icount", icount, 16'(mdl_n));
        chk("loop_cycles", 64'(cyc), 64'(2 * mdl_n));
        chk("loop_acc", acc, 16'd0);

        // Busy protection: load and start during a run are ignored
        pulse_start();
        @(negedge clk);
        load_en = 1'b1; load_addr = 8'd0; load_data = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        wait_halt(2, cyc);
        chk("busy_no_restart", 64'(cyc), 64'd20);
        chk("busy_mem0", dut.u_mem.r_mem[0], ins(LDA, 30));
        chk("busy_icount", icount, 16'd10);
        pulse_start();
        chk("rerun_init", {pc, busy, halted, icount}, {8'd0, 1'b1, 1'b0, 16'd0});
        wait_halt(0, cyc);
        chk("rerun_cycles", 64'(cyc), 64'd20);

        // Load and start in the same cycle: first fetch sees the new word
        @(negedge clk);
        load_en = 1'b1; load_addr = 8'd0; load_data = ins(HALT, 0); start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        tb_mem[0] = ins(HALT, 0);
        wait_halt(0, cyc);
        chk("ldstart_cycles", 64'(cyc), 64'd2);
        chk("ldstart_icount", icount, 16'd1);

        // Reset during EXEC of a STA
        load(0, ins(LDA, 30)); load(1, ins(STA, 40)); load(2, ins(HALT, 0));
        load(30, 16'd3); load(40, 16'h1234);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrun_reset_outputs", {acc, pc, busy, halted, carry, icount}, 64'd0);
        repeat (2) @(negedge clk);
        chk("sta_aborted", dut.u_mem.r_mem[40], 16'h1234);
        reset = 1'b1;
        pulse_start();
        wait_halt(0, cyc);
        chk("post_reset_cycles", 64'(cyc), 64'd6);
        chk("post_reset_mem40", dut.u_mem.r_mem[40], 16'd3);
        tb_mem[40] = 16'd3;

        // Random straight-line programs with forward jumps and junk bits
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 6; i++) begin
                logic [2:0]  op;
                logic [7:0]  a;
                logic [15:0] w;
                op = 3'($urandom_range(1, 7));
                a  = (op >= JMP) ? 8'(i + 2) : 8'(100 + $urandom_range(0, 7));
                w  = ins(op, a);
                w[12:8] = 5'($urandom);
                load(8'(i), w);
            end
            load(6, ins(HALT, 0)); load(7, ins(HALT, 0));
            for (int d = 0; d < 8; d++) load(8'(100 + d), 16'($urandom));
            run_model();
            pulse_start();
            wait_halt(0, cyc);
            chk("rnd_cycles", 64'(cyc), 64'(2 * mdl_n));
            chk("rnd_acc", acc, mdl_acc);
            chk("rnd_carry", carry, mdl_c);
            chk("rnd_icount", icount, 16'(mdl_n));
            chk("rnd_pc", pc, mdl_pc);
            for (int d = 100; d < 108; d++) chk("rnd_mem", dut.u_mem.r_mem[d], mdl_mem[d]);
            tb_mem = mdl_mem;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
